// File: rtl/echo_serializer_pkg.sv
// Shared types and helpers for the multi-echo serializer.
// Optional intensity filter is enabled with ECHO_PULSE_FILTER_EN.
package echo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int unsigned GAP_CNT_W = 8;

  // Slot-index width, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : 32'($clog2(n));
  endfunction

  // NO_ECHO marker: all ones over the input distance width.
  function automatic logic [31:0] no_echo_dist(input int unsigned dist_w);
    return (dist_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << dist_w) - 32'd1);
  endfunction

endpackage

// File: rtl/echo_serializer_if.sv
// Frame-in / echo-out handshake bundle for echo_serializer.
// min_pulse exists only when ECHO_PULSE_FILTER_EN is defined.
interface echo_serializer_if #(
  parameter int unsigned N_ECHO      = 5,
  parameter int unsigned DIST_W      = 16,
  parameter int unsigned PULSE_W     = 8,
  parameter int unsigned OUT_DIST_W  = 18,
  parameter int unsigned OUT_PULSE_W = 12,
  parameter int unsigned IDX_W       = echo_pkg::idx_width(N_ECHO)
) ();

  logic                       in_valid;
  logic                       in_ready;
  logic [N_ECHO*PULSE_W-1:0]  in_pulse;
  logic [N_ECHO*DIST_W-1:0]   in_dist;
`ifdef ECHO_PULSE_FILTER_EN
  logic [PULSE_W-1:0]         min_pulse;
`endif
  logic                       out_valid;
  logic                       out_ready;
  logic [OUT_DIST_W-1:0]      out_dist;
  logic [OUT_PULSE_W-1:0]     out_pulse;
  logic [IDX_W-1:0]           out_idx;
  logic                       out_last;
  logic                       overrun;

  // Environment side: offers frames, consumes echoes.
  modport master (
`ifdef ECHO_PULSE_FILTER_EN
    output min_pulse,
`endif
    output in_valid, in_pulse, in_dist, out_ready,
    input  in_ready, out_valid, out_dist, out_pulse, out_idx, out_last, overrun
  );

  // Serializer side.
  modport slave (
`ifdef ECHO_PULSE_FILTER_EN
    input  min_pulse,
`endif
    input  in_valid, in_pulse, in_dist, out_ready,
    output in_ready, out_valid, out_dist, out_pulse, out_idx, out_last, overrun
  );

endinterface

// File: rtl/echo_serializer_pick.sv
// Find-first-set over the echo mask: lowest slot, any-set and
// exactly-one-set flags.
module echo_pick #(
  parameter int unsigned N_ECHO = 5,
  parameter int unsigned IDX_W  = 3
) (
  input  logic [N_ECHO-1:0] mask_i,
  output logic [IDX_W-1:0]  idx_c_o,
  output logic              found_c_o,
  output logic              only_one_c_o
);

  always_comb begin
    idx_c_o   = '0;
    found_c_o = 1'b0;
    // Scan downwards so the lowest set bit wins.
    for (int i = int'(N_ECHO) - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_c_o   = IDX_W'(i);
        found_c_o = 1'b1;
      end
    end
    only_one_c_o = found_c_o && ((mask_i & (mask_i - N_ECHO'(1))) == '0);
  end

endmodule

// File: rtl/echo_serializer.sv
// Multi-echo serializer: latches a frame of N_ECHO slots and emits the
// non-empty ones in slot order with a GAP-cycle spacing (ECHO_PULSE_FILTER_EN
// adds a minimum-pulse qualifier on each slot).
module echo_serializer
  import echo_pkg::*;
#(
  parameter int unsigned N_ECHO      = 5,
  parameter int unsigned DIST_W      = 16,
  parameter int unsigned PULSE_W     = 8,
  parameter int unsigned OUT_DIST_W  = 18,
  parameter int unsigned OUT_PULSE_W = 12,
  parameter int unsigned GAP         = 20
) (
  input  logic             clk,
  input  logic             rst,
  echo_serializer_if.slave bus
);

  localparam int unsigned IDX_W = idx_width(N_ECHO);
  localparam logic [OUT_DIST_W-1:0] NO_ECHO = OUT_DIST_W'(no_echo_dist(DIST_W));
  localparam logic [GAP_CNT_W-1:0]  GAP_RELOAD = GAP_CNT_W'(GAP - 1);

  state_e                     state_q, state_d;
  logic [N_ECHO-1:0]          mask_q, mask_d;
  logic [N_ECHO*PULSE_W-1:0]  pulse_q, pulse_d;
  logic [N_ECHO*DIST_W-1:0]   dist_q, dist_d;
  logic [GAP_CNT_W-1:0]       gap_q, gap_d;

  logic                       in_ready_q, in_ready_d;
  logic                       out_valid_q, out_valid_d;
  logic                       out_last_q, out_last_d;
  logic                       overrun_q, overrun_d;
  logic [OUT_DIST_W-1:0]      out_dist_q, out_dist_d;
  logic [OUT_PULSE_W-1:0]     out_pulse_q, out_pulse_d;
  logic [IDX_W-1:0]           out_idx_q, out_idx_d;

  logic                       accept;
  logic                       xfer;
  logic                       load_word;
  logic [N_ECHO-1:0]          new_mask;
  logic [N_ECHO-1:0]          clr_mask;
  logic [N_ECHO-1:0]          pick_src;
  logic [N_ECHO*PULSE_W-1:0]  src_pulse;
  logic [N_ECHO*DIST_W-1:0]   src_dist;
  logic [IDX_W-1:0]           pick_idx;
  logic                       pick_found;
  logic                       pick_one;
  logic [PULSE_W-1:0]         sel_pulse;
  logic [DIST_W-1:0]          sel_dist;

  assign accept = in_ready_q && bus.in_valid;
  assign xfer   = out_valid_q && bus.out_ready;

  // Slot occupancy of the frame currently on the input bus.
  always_comb begin
    new_mask = '0;
    for (int k = 0; k < int'(N_ECHO); k++) begin
      new_mask[k] = (bus.in_dist[k*DIST_W +: DIST_W] != '0)
`ifdef ECHO_PULSE_FILTER_EN
                    && (bus.in_pulse[k*PULSE_W +: PULSE_W] >= bus.min_pulse)
`endif
                    ;
    end
  end

  // While idle the picker looks at the incoming frame, otherwise at the
  // stored mask with the word just presented already removed.
  assign clr_mask  = mask_q & ~(N_ECHO'(1) << out_idx_q);
  assign pick_src  = (state_q == ST_IDLE) ? new_mask     : clr_mask;
  assign src_pulse = (state_q == ST_IDLE) ? bus.in_pulse : pulse_q;
  assign src_dist  = (state_q == ST_IDLE) ? bus.in_dist  : dist_q;
  assign sel_pulse = src_pulse[pick_idx*PULSE_W +: PULSE_W];
  assign sel_dist  = src_dist[pick_idx*DIST_W +: DIST_W];

  echo_pick #(
    .N_ECHO (N_ECHO),
    .IDX_W  (IDX_W)
  ) u_pick (
    .mask_i       (pick_src),
    .idx_c_o      (pick_idx),
    .found_c_o    (pick_found),
    .only_one_c_o (pick_one)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      pulse_q     <= '0;
      dist_q      <= '0;
      gap_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overrun_q   <= 1'b0;
      out_dist_q  <= '0;
      out_pulse_q <= '0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      pulse_q     <= pulse_d;
      dist_q      <= dist_d;
      gap_q       <= gap_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      overrun_q   <= overrun_d;
      out_dist_q  <= out_dist_d;
      out_pulse_q <= out_pulse_d;
      out_idx_q   <= out_idx_d;
    end
  end

  // Next-state: frame capture, mask retirement and gap counting.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    pulse_d   = pulse_q;
    dist_d    = dist_q;
    gap_d     = gap_q;
    load_word = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          pulse_d   = bus.in_pulse;
          dist_d    = bus.in_dist;
          mask_d    = new_mask;
          state_d   = ST_EMIT;
          load_word = 1'b1;
        end
      end
      ST_EMIT: begin
        if (xfer) begin
          mask_d = clr_mask;
          if (out_last_q) begin
            mask_d  = '0;
            state_d = ST_IDLE;
          end else if (GAP == 0) begin
            load_word = 1'b1;
          end else begin
            state_d = ST_GAP;
            gap_d   = GAP_RELOAD;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d   = ST_EMIT;
          load_word = 1'b1;
        end else begin
          gap_d = gap_q - GAP_CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        mask_d  = '0;
      end
    endcase
  end

  // Output next-values: words only change on load, so a stalled word holds.
  always_comb begin
    in_ready_d  = (state_d == ST_IDLE);
    overrun_d   = bus.in_valid && !in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_dist_d  = out_dist_q;
    out_pulse_d = out_pulse_q;
    out_idx_d   = out_idx_q;
    if (load_word) begin
      out_valid_d = 1'b1;
      if (pick_found) begin
        out_dist_d  = OUT_DIST_W'(sel_dist);
        out_pulse_d = OUT_PULSE_W'(sel_pulse);
        out_idx_d   = pick_idx;
        out_last_d  = pick_one;
      end else begin
        out_dist_d  = NO_ECHO;
        out_pulse_d = '0;
        out_idx_d   = '0;
        out_last_d  = 1'b1;
      end
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.overrun   = overrun_q;
  assign bus.out_dist  = out_dist_q;
  assign bus.out_pulse = out_pulse_q;
  assign bus.out_idx   = out_idx_q;

endmodule
